// File: rtl/mdu_scheduler_pkg.sv
// Shared CPU definitions for the multiply/divide unit: opcodes, read selects,
// scheduler states and default latencies.
package mdu_scheduler_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  localparam logic [1:0] READ_HI = 2'd1;
  localparam logic [1:0] READ_LO = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam logic [3:0] LAT_MULT = 4'd5;
  localparam logic [3:0] LAT_DIV  = 4'd10;

  // Operations that produce a 64-bit result and occupy the unit.
  function automatic logic is_arith_op(input logic [3:0] op);
    logic hit;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: hit = 1'b1;
      default:                                hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mdu_scheduler_if.sv
// E-stage issue / D-stage hazard bundle between the pipeline and the MD unit.
interface mdu_scheduler_if;
  logic        Start;
  logic [3:0]  MDUOP;
  logic [3:0]  Time;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  ReadHILO;
  logic        MDInD;
  logic        Busy;
  logic        Stall;
  logic [31:0] HILOOut;

  modport master (
    output Start, MDUOP, Time, A, B, ReadHILO, MDInD,
    input  Busy, Stall, HILOOut
  );

  modport slave (
    input  Start, MDUOP, Time, A, B, ReadHILO, MDInD,
    output Busy, Stall, HILOOut
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: result is {HI, LO}, plus a flag
// telling the scheduler that a divide by zero must not touch HI/LO.
module mdu_arith
  import mdu_scheduler_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] smul_s;
  logic [63:0]        umul_s;
  logic [31:0]        divisor_s;
  logic [31:0]        uq_s;
  logic [31:0]        ur_s;
  logic [31:0]        a_mag_s;
  logic [31:0]        b_mag_s;
  logic [31:0]        sq_mag_s;
  logic [31:0]        sr_mag_s;
  logic [31:0]        sq_s;
  logic [31:0]        sr_s;

  // Signed divide works on magnitudes; a zero divisor is replaced by one so
  // the datapath never divides by zero (the result is discarded anyway).
  always_comb begin
    smul_s    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    umul_s    = {32'd0, a} * {32'd0, b};
    divisor_s = (b == 32'd0) ? 32'd1 : b;
    uq_s      = a / divisor_s;
    ur_s      = a % divisor_s;
    a_mag_s   = a[31] ? (32'd0 - a) : a;
    b_mag_s   = divisor_s[31] ? (32'd0 - divisor_s) : divisor_s;
    sq_mag_s  = a_mag_s / b_mag_s;
    sr_mag_s  = a_mag_s % b_mag_s;
    sq_s      = (a[31] ^ divisor_s[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
    sr_s      = a[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
  end

  // Opcode select of the final {HI, LO} value.
  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  result = smul_s;
      MDU_MULTU: result = umul_s;
      MDU_DIV: begin
        result   = {sr_s, sq_s};
        div_zero = (b == 32'd0);
      end
      MDU_DIVU: begin
        result   = {ur_s, uq_s};
        div_zero = (b == 32'd0);
      end
      default: begin
        result   = 64'd0;
        div_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_scheduler.sv
// Multiply/divide scheduler: holds HI/LO, a pending result and the latency
// counter, and raises the D-stage stall while an MD op is in flight.
module mdu_scheduler
  import mdu_scheduler_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mdu_scheduler_if.slave bus
);

  mdu_state_e  state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] hi_r, hi_s;
  logic [31:0] lo_r, lo_s;
  logic [31:0] phi_r, phi_s;
  logic [31:0] plo_r, plo_s;
  logic [63:0] result_s;
  logic        div_zero_s;
  logic        busy_s;

  mdu_arith u_arith (
    .a        (bus.A),
    .b        (bus.B),
    .op       (bus.MDUOP),
    .result   (result_s),
    .div_zero (div_zero_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counter, committed and pending result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
      hi_r  <= 32'd0;
      lo_r  <= 32'd0;
      phi_r <= 32'd0;
      plo_r <= 32'd0;
    end else begin
      cnt_r <= cnt_s;
      hi_r  <= hi_s;
      lo_r  <= lo_s;
      phi_r <= phi_s;
      plo_r <= plo_s;
    end
  end

  // Next state and register updates; Start is ignored while running.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    phi_s   = phi_r;
    plo_s   = plo_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.Start) begin
          if (is_arith_op(bus.MDUOP)) begin
            if (bus.Time == 4'd0) begin
              if (!div_zero_s) begin
                hi_s = result_s[63:32];
                lo_s = result_s[31:0];
              end else begin
                hi_s = hi_r;
                lo_s = lo_r;
              end
            end else begin
              // HI/LO cannot change during RUN, so parking them in the
              // pending pair makes a divide-by-zero commit a no-op.
              phi_s   = div_zero_s ? hi_r : result_s[63:32];
              plo_s   = div_zero_s ? lo_r : result_s[31:0];
              cnt_s   = bus.Time;
              state_s = ST_RUN;
            end
          end else if (bus.MDUOP == MDU_MTHI) begin
            hi_s = bus.A;
          end else if (bus.MDUOP == MDU_MTLO) begin
            lo_s = bus.A;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          hi_s    = phi_r;
          lo_s    = plo_r;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Read mux over committed values only.
  always_comb begin
    bus.HILOOut = 32'd0;
    case (bus.ReadHILO)
      READ_HI: bus.HILOOut = hi_r;
      READ_LO: bus.HILOOut = lo_r;
      default: bus.HILOOut = 32'd0;
    endcase
  end

  assign busy_s    = (state_r == ST_RUN);
  assign bus.Busy  = busy_s;
  assign bus.Stall = bus.MDInD & (bus.Start | busy_s);

endmodule

// File: tb/tb_mdu_scheduler.sv
// Self-checking bench for mdu_scheduler: directed corner cases plus random
// operations compared against a transaction-level HI/LO model.
module tb_mdu_scheduler;
  import mdu_scheduler_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mdu_scheduler_if bus ();

  mdu_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sel_val(input logic [1:0] sel, input logic [31:0] h, input logic [31:0] l);
    if (sel == 2'd1) return h;
    if (sel == 2'd2) return l;
    return 32'd0;
  endfunction

  // Architectural effect of one operation on HI/LO.
  function automatic void model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] nh, output logic [31:0] nl);
    longint      sp;
    logic [63:0] up;
    int          q;
    int          r;
    nh = m_hi;
    nl = m_lo;
    case (op)
      4'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        nh = sp[63:32];
        nl = sp[31:0];
      end
      4'd2: begin
        up = {32'd0, a} * {32'd0, b};
        nh = up[63:32];
        nl = up[31:0];
      end
      4'd3: begin
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            nl = 32'h8000_0000;
            nh = 32'd0;
          end else begin
            q  = $signed(a) / $signed(b);
            r  = $signed(a) % $signed(b);
            nl = q;
            nh = r;
          end
        end
      end
      4'd4: begin
        if (b != 32'd0) begin
          nl = a / b;
          nh = a % b;
        end
      end
      4'd5: nh = a;
      4'd6: nl = a;
      default: ;
    endcase
  endfunction

  task automatic check_hilo(input string tag);
    bus.ReadHILO = 2'd1; #1; check_val({tag, "_hi"}, bus.HILOOut, m_hi);
    bus.ReadHILO = 2'd2; #1; check_val({tag, "_lo"}, bus.HILOOut, m_lo);
    bus.ReadHILO = 2'd3; #1; check_val({tag, "_sel3"}, bus.HILOOut, 32'd0);
  endtask

  task automatic expect_hl(input string tag, input logic [31:0] h, input logic [31:0] l);
    bus.ReadHILO = 2'd1; #1; check_val({tag, "_hi_const"}, bus.HILOOut, h);
    bus.ReadHILO = 2'd2; #1; check_val({tag, "_lo_const"}, bus.HILOOut, l);
  endtask

  // Issue one op, check Busy/Stall/HILOOut every cycle until it is committed.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [3:0] tm,
                       input logic [31:0] a, input logic [31:0] b, input logic md);
    logic [31:0] nh;
    logic [31:0] nl;
    int          lat;
    @(negedge clk);
    bus.Start    = 1'b1;
    bus.MDUOP    = op;
    bus.Time     = tm;
    bus.A        = a;
    bus.B        = b;
    bus.MDInD    = md;
    bus.ReadHILO = 2'($urandom_range(0, 3));
    #1;
    check_val({tag, "_start_stall"}, {31'd0, bus.Stall}, {31'd0, md});
    check_val({tag, "_start_busy"}, {31'd0, bus.Busy}, 32'd0);
    check_val({tag, "_start_out"}, bus.HILOOut, sel_val(bus.ReadHILO, m_hi, m_lo));
    model_exec(op, a, b, nh, nl);
    lat = (op >= 4'd1 && op <= 4'd4) ? int'(tm) : 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      bus.Start    = 1'b0;
      bus.A        = $urandom;
      bus.B        = $urandom;
      bus.ReadHILO = 2'($urandom_range(0, 3));
      #1;
      check_val({tag, "_run_busy"}, {31'd0, bus.Busy}, 32'd1);
      check_val({tag, "_run_stall"}, {31'd0, bus.Stall}, {31'd0, md});
      check_val({tag, "_run_out"}, bus.HILOOut, sel_val(bus.ReadHILO, m_hi, m_lo));
    end
    m_hi = nh;
    m_lo = nl;
    @(negedge clk);
    bus.Start = 1'b0;
    #1;
    check_val({tag, "_done_busy"}, {31'd0, bus.Busy}, 32'd0);
    check_val({tag, "_done_stall"}, {31'd0, bus.Stall}, 32'd0);
    check_hilo(tag);
  endtask

  initial begin
    bus.Start    = 1'b0;
    bus.MDUOP    = 4'd0;
    bus.Time     = 4'd0;
    bus.A        = 32'd0;
    bus.B        = 32'd0;
    bus.ReadHILO = 2'd0;
    bus.MDInD    = 1'b0;

    #12;
    check_val("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check_hilo("rst");
    bus.MDInD = 1'b1;
    bus.Start = 1'b1;
    #1;
    check_val("rst_stall_start", {31'd0, bus.Stall}, 32'd1);
    bus.Start = 1'b0;
    #1;
    check_val("rst_stall_idle", {31'd0, bus.Stall}, 32'd0);
    bus.MDInD = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mult", 4'd1, 4'd5, 32'hFFFF_FFFE, 32'd3, 1'b0);
    expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("divu", 4'd4, 4'd10, 32'd100, 32'd7, 1'b1);
    expect_hl("divu", 32'd2, 32'd14);
    do_op("div_neg", 4'd3, 4'd10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    expect_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_zero", 4'd3, 4'd10, 32'd5, 32'd0, 1'b1);
    expect_hl("div_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_ovf", 4'd3, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    expect_hl("div_ovf", 32'd0, 32'h8000_0000);
    do_op("mthi", 4'd5, 4'd7, 32'h1234_5678, 32'd0, 1'b1);
    expect_hl("mthi", 32'h1234_5678, 32'h8000_0000);
    do_op("mtlo", 4'd6, 4'd0, 32'hCAFE_F00D, 32'd0, 1'b0);
    do_op("multu0", 4'd2, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    expect_hl("multu0", 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("nop", 4'd9, 4'd4, 32'h1111_1111, 32'h2222_2222, 1'b1);

    // Reset asserted during the third busy cycle of a MULT.
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOP = 4'd1; bus.Time = 4'd5;
    bus.A = 32'd7; bus.B = 32'd9; bus.MDInD = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check_val("mid_busy_before", {31'd0, bus.Busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", {31'd0, bus.Busy}, 32'd0);
    check_val("mid_rst_stall", {31'd0, bus.Stall}, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    check_hilo("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check_val("post_rst_busy", {31'd0, bus.Busy}, 32'd0);
    check_hilo("post_rst");
    bus.MDInD = 1'b0;

    for (int k = 0; k < 40; k++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      do_op("rand", op, 4'($urandom_range(0, 12)), a, b, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_scheduler.md
MDU_SCHEDULER -- requirements
Module: mdu_scheduler

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port: Start  input  1  E-stage pulse; MD operation issued this cycle.
REQ-004 SHALL provide port: MDUOP  input  4  operation code, sampled when Start=1.
REQ-005 SHALL provide port: Time  input  4  operation latency in cycles, sampled when Start=1.
REQ-006 SHALL provide port: A, B  input  32 each  forwarded rs/rt operands from E stage.
REQ-007 SHALL provide port: ReadHILO  input  2  read select: 1=HI, 2=LO, other=zero.
REQ-008 SHALL provide port: MDInD  input  1  D stage holds an MD-class instruction (mult/div/mf/mt).
REQ-009 SHALL provide port: Busy  output  1  operation in flight.
REQ-010 SHALL provide port: Stall  output  1  D-stage stall request.
REQ-011 SHALL provide port: HILOOut  output  32  selected HI/LO value.
REQ-012 SHALL use parameter: none; all encodings come from the shared package.

Function
REQ-013 SHALL use MDUOP encoding: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-15 treated as NONE.
REQ-014 SHALL implement two states: IDLE and RUN, with a 4-bit down-counter Cnt.
REQ-015 SHALL, in IDLE with Start=1, op in MULT..DIVU, and Time>=1: latch the computed result into pending registers PHI/PLO, load Cnt=Time, and enter RUN.
REQ-016 SHALL, in IDLE with Start=1, op in MULT..DIVU, and Time=0: commit the result to HI/LO on the same edge and stay in IDLE.
REQ-017 SHALL compute results as follows:
- MULT: signed 64-bit product {HI,LO}=A*B.
- MULTU: unsigned 64-bit product.
- DIV: signed, LO=quotient, HI=remainder, remainder takes the dividend's sign.
- DIVU: unsigned quotient/remainder.
REQ-018 SHALL, for DIV/DIVU with B=0, leave HI/LO unchanged at commit while still running the full Time-cycle latency.
REQ-019 SHALL, for signed DIV of 0x80000000 by 0xFFFFFFFF, produce LO=0x80000000, HI=0.
REQ-020 SHALL, in RUN, decrement Cnt each cycle; on the edge where Cnt=1, copy PHI/PLO to HI/LO and return to IDLE.
REQ-021 SHALL assert Busy=1 exactly while in RUN, i.e. for Time cycles following the Start cycle.
REQ-022 SHALL, on MTHI/MTLO with Start=1 in IDLE, write A into HI/LO respectively on that edge with no busy period.
REQ-023 SHALL ignore Start while in RUN (no state change, no register write); the hazard unit guarantees this does not occur.
REQ-024 SHALL drive Stall = MDInD & (Start | Busy), combinationally.
REQ-025 SHALL drive HILOOut combinationally from the committed HI/LO only; pending results are never visible.

Reset
REQ-026 SHALL, while rst_n=0, immediately force: state=IDLE, Cnt=0, HI=0, LO=0, PHI=0, PLO=0, Busy=0.
REQ-027 SHALL, on reset asserted mid-RUN, discard the pending result; HI/LO read 0 after reset.
REQ-028 SHALL, on reset, make Stall and HILOOut follow from the reset state (Stall=MDInD&Start, HILOOut=0).

Structure
REQ-029 SHALL place the MDUOP encodings, the ReadHILO select codes, the state enum, and default latencies (MULT=5, DIV=10) in the shared CPU definitions package.
REQ-030 SHALL implement the arithmetic as one combinational sub-module, mdu_arith (A, B, MDUOP -> 64-bit result plus div-by-zero flag); the scheduler holds all sequential state.

Verification
REQ-031 SHALL cover: MULT A=0xFFFFFFFE B=3 Time=5 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HILOOut shows old value throughout Busy.
REQ-032 SHALL cover: DIVU A=100 B=7 Time=10 with MDInD=1 during the run -> Stall=1 for 11 cycles (Start cycle + 10), then LO=14, HI=2.
REQ-033 SHALL cover: DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV A=5 B=0 -> HI/LO unchanged after 10 busy cycles.
REQ-034 SHALL cover: MTHI A=0x12345678, then ReadHILO=1 next cycle -> HILOOut=0x12345678, Busy never asserted.
REQ-035 SHALL cover: rst_n pulsed low at cycle 3 of a MULT -> Busy=0 asynchronously, HI=LO=0, no commit afterwards.
REQ-036 SHALL cover: Start with MULTU Time=0 -> commit on the same edge, Busy stays 0.
